game_tick_scheduler: RTL and testbench

Multi-channel periodic event scheduler driven by the 1 ms tick strobe from the board clock divider. Holds NCH independent, software-configurable millisecond timers and emits one-clock event pulses used to pace game logic: enemy movement, bullet advance, spawn, animation. Also keeps a free-running game-time millisecond counter. A global `run` input pauses all channels together.

---
 rtl/game_tick_scheduler.sv | 88 ++++++++
 tb/tb_game_tick_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Multi-channel millisecond event scheduler with a free-running game-time counter.
// Each channel reloads from its period and pulses evt for one clk when its count expires.
module game_tick_scheduler #(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = 12,
  parameter int unsigned CW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_1ms,
  input  logic            run,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic            cfg_en,
  input  logic [PW-1:0]   cfg_period,
  output logic [NCH-1:0]  evt,
  output logic [15:0]     game_ms,
  output logic [NCH-1:0]  active
);

  localparam int unsigned GW = 16;
  localparam int unsigned SW = CW + 1;

  logic [PW-1:0]  period_q [NCH];
  logic [PW-1:0]  period_d [NCH];
  logic [PW-1:0]  cnt_q    [NCH];
  logic [PW-1:0]  cnt_d    [NCH];
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] evt_q, evt_d;
  logic [NCH-1:0] active_q, active_d;
  logic [GW-1:0]  game_ms_q, game_ms_d;
  logic           adv_c;
  logic           cfg_valid_c;

  // Next-state: a config write to a channel pre-empts that channel's tick.
  always_comb begin
    adv_c       = tick_1ms && run;
    cfg_valid_c = cfg_we && ({1'b0, cfg_ch} < SW'(NCH));
    game_ms_d   = adv_c ? game_ms_q + GW'(1) : game_ms_q;
    en_d        = en_q;
    evt_d       = '0;
    active_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      if (cfg_valid_c && (cfg_ch == CW'(i))) begin
        period_d[i] = cfg_period;
        cnt_d[i]    = cfg_period;
        en_d[i]     = cfg_en;
      end else if (adv_c && en_q[i] && (period_q[i] != '0)) begin
        if (cnt_q[i] == PW'(1)) begin
          evt_d[i] = 1'b1;
          cnt_d[i] = period_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - PW'(1);
        end
      end
      active_d[i] = en_d[i] && (period_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      en_q      <= '0;
      evt_q     <= '0;
      active_q  <= '0;
      game_ms_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      en_q      <= en_d;
      evt_q     <= evt_d;
      active_q  <= active_d;
      game_ms_q <= game_ms_d;
    end
  end

  assign evt     = evt_q;
  assign game_ms = game_ms_q;
  assign active  = active_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: periods, mixing, pause, collisions, reset, wrap.
module tb_game_tick_scheduler;

  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = 12;
  localparam int unsigned CW  = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick_1ms;
  logic           run;
  logic           cfg_we;
  logic [CW-1:0]  cfg_ch;
  logic           cfg_en;
  logic [PW-1:0]  cfg_period;
  logic [NCH-1:0] evt;
  logic [15:0]    game_ms;
  logic [NCH-1:0] active;

  int checks = 0;
  int errors = 0;

  game_tick_scheduler #(.NCH(NCH), .PW(PW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms), .run(run),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_period(cfg_period),
    .evt(evt), .game_ms(game_ms), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick_1ms = 1'b1;
    @(posedge clk);
    #1;
    tick_1ms = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic en, input int p);
    cfg_we     = 1'b1;
    cfg_ch     = CW'(ch);
    cfg_en     = en;
    cfg_period = PW'(p);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // One tick, check evt right after it and one clk later, then space to 5 clocks.
  task automatic tick_chk(input string tag, input logic [NCH-1:0] exp_evt);
    do_tick();
    chk(tag, 32'(evt), 32'(exp_evt));
    idle(1);
    chk({tag, "_low"}, 32'(evt), 32'(0));
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0; tick_1ms = 1'b0; run = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_period = '0;

    // Reset held 3 cycles with tick pulsing
    repeat (3) begin
      tick_1ms = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_evt", 32'(evt), 32'(0));
      chk("rst_ms", 32'(game_ms), 32'(0));
      chk("rst_active", 32'(active), 32'(0));
    end
    tick_1ms = 1'b0;
    rst_n = 1'b1;
    idle(1);
    chk("rel_evt", 32'(evt), 32'(0));
    chk("rel_ms", 32'(game_ms), 32'(0));
    chk("rel_active", 32'(active), 32'(0));

    // ch0 period 3
    cfg(0, 1'b1, 3);
    idle(1);
    chk("p3_active", 32'(active), 32'(4'b0001));
    for (int k = 1; k <= 9; k++)
      tick_chk("p3_evt", (k % 3 == 0) ? 4'b0001 : 4'b0000);
    chk("p3_ms", 32'(game_ms), 32'(9));

    // Mixed channels
    cfg(0, 1'b0, 0);
    cfg(1, 1'b1, 1);
    cfg(2, 1'b1, 2);
    cfg(3, 1'b1, 0);
    idle(1);
    chk("mix_active", 32'(active), 32'(4'b0110));
    tick_chk("mix_t1", 4'b0010);
    tick_chk("mix_t2", 4'b0110);
    tick_chk("mix_t3", 4'b0010);
    tick_chk("mix_t4", 4'b0110);
    chk("mix_ms", 32'(game_ms), 32'(13));

    // Pause
    cfg(1, 1'b0, 1);
    cfg(2, 1'b0, 2);
    cfg(3, 1'b0, 0);
    cfg(0, 1'b1, 4);
    tick_chk("pz_t1", 4'b0000);
    tick_chk("pz_t2", 4'b0000);
    chk("pz_ms_pre", 32'(game_ms), 32'(15));
    run = 1'b0;
    for (int k = 0; k < 10; k++) tick_chk("pz_paused", 4'b0000);
    chk("pz_ms_frozen", 32'(game_ms), 32'(15));
    run = 1'b1;
    tick_chk("pz_r1", 4'b0000);
    tick_chk("pz_r2", 4'b0001);
    chk("pz_ms_post", 32'(game_ms), 32'(17));

    // Collision: write at the tick where cnt==1
    tick_chk("col_a", 4'b0000);
    tick_chk("col_b", 4'b0000);
    tick_chk("col_c", 4'b0000);
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_en = 1'b1; cfg_period = 12'd5;
    tick_1ms = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; tick_1ms = 1'b0;
    chk("col_noevt", 32'(evt), 32'(0));
    idle(3);
    for (int k = 1; k <= 5; k++)
      tick_chk("col_p5", (k == 5) ? 4'b0001 : 4'b0000);
    chk("col_ms", 32'(game_ms), 32'(26));

    // Out-of-range channel write is ignored
    cfg(5, 1'b1, 7);
    idle(1);
    chk("oor_active", 32'(active), 32'(4'b0001));
    for (int k = 1; k <= 5; k++)
      tick_chk("oor_p5", (k == 5) ? 4'b0001 : 4'b0000);

    // Reset the cycle after a firing tick
    for (int k = 1; k <= 4; k++) tick_chk("rmid_pre", 4'b0000);
    do_tick();
    chk("rmid_fire", 32'(evt), 32'(4'b0001));
    rst_n = 1'b0;
    idle(1);
    chk("rmid_evt", 32'(evt), 32'(0));
    chk("rmid_active", 32'(active), 32'(0));
    chk("rmid_ms", 32'(game_ms), 32'(0));
    rst_n = 1'b1;
    idle(1);

    // Reset coincident with a firing tick suppresses the pending event
    cfg(1, 1'b1, 1);
    idle(1);
    chk("rsup_active_pre", 32'(active), 32'(4'b0010));
    rst_n = 1'b0; tick_1ms = 1'b1;
    @(posedge clk);
    #1;
    tick_1ms = 1'b0;
    chk("rsup_evt", 32'(evt), 32'(0));
    chk("rsup_active", 32'(active), 32'(0));
    rst_n = 1'b1;
    idle(1);
    chk("rsup_ms", 32'(game_ms), 32'(0));

    // game_ms wrap with tick held high
    tick_1ms = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", 32'(game_ms), 32'(16'hFFFF));
    @(posedge clk);
    #1;
    tick_1ms = 1'b0;
    chk("wrap_zero", 32'(game_ms), 32'(0));
    chk("wrap_evt", 32'(evt), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
